// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//   - opcode / funct constants for the supported instruction subset
//   - 4-bit ALU operation codes
//   - ctrl_t: packed control bundle carried by the ID/EX and EX/MEM registers
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       illegal;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// id_ctrl_decode: combinational opcode/funct decoder.
//   opcode, funct, rt, rd  in   instruction fields
//   ctrl                   out  control bundle (reg_write already cleared for $0)
//   dst                    out  destination register (0 when nothing is written)
//   rt_used                out  rt is a source operand (R-type, sw, beq)
module id_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic [4:0] dst,
    output logic       rt_used
);

    always_comb begin
        ctrl    = '0;
        dst     = '0;
        rt_used = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rt_used        = 1'b1;
                dst            = rd;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.illegal   = 1'b1;
                        dst            = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                dst            = rt;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                dst             = rt;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                rt_used        = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                rt_used      = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_SUB;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // Writes to $0 are architecturally discarded; drop them here so the
        // hazard and forwarding logic downstream never sees them.
        if (dst == 5'd0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage and ID/EX pipeline register.
//   clk, rst (sync, active-low)
//   if_valid, if_instr, if_pc4      IF/ID register contents
//   flush                           squash current decode
//   id_stall                        hold PC and IF/ID (load-use hazard)
//   rf_read_reg1/2, rf_read_data1/2 register-file read port
//   wb_reg_write/write_reg/write_data  writeback bus
//   ex_*                            registered ID/EX outputs
// Optional macro WB_BYPASS_EN: forward same-cycle writeback data into the
// captured operands instead of the (not yet updated) register-file data.
module id_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic              flush,
    output logic              id_stall,
    output logic [4:0]        rf_read_reg1,
    output logic [4:0]        rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_illegal,
    output logic [3:0]        ex_alu_op
);

    logic [4:0]        rs;
    logic [4:0]        rt;
    ctrl_t             dec_ctrl;
    logic [4:0]        dec_dst;
    logic              dec_rt_used;
    logic              hazard;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;

    assign rs           = if_instr[25:21];
    assign rt           = if_instr[20:16];
    assign rf_read_reg1 = rs;
    assign rf_read_reg2 = rt;
    assign imm          = {{16{if_instr[15]}}, if_instr[15:0]};

    id_ctrl_decode u_decode (
        .opcode  (if_instr[31:26]),
        .funct   (if_instr[5:0]),
        .rt      (rt),
        .rd      (if_instr[15:11]),
        .ctrl    (dec_ctrl),
        .dst     (dec_dst),
        .rt_used (dec_rt_used)
    );

    assign hazard = ex_valid && ex_mem_read && (ex_dst != 5'd0) && if_valid &&
                    ((ex_dst == rs) || (dec_rt_used && (ex_dst == rt)));

    // Reset and flush both discard the upstream instruction, so no stall.
    assign id_stall = rst && !flush && hazard;

`ifdef WB_BYPASS_EN
    always_comb begin
        rs_data = rf_read_data1;
        rt_data = rf_read_data2;
        if (wb_reg_write && (wb_write_reg != 5'd0)) begin
            if (wb_write_reg == rs) rs_data = wb_write_data;
            if (wb_write_reg == rt) rt_data = wb_write_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
    assign rs_data   = rf_read_data1;
    assign rt_data   = rf_read_data2;
`endif

    always_ff @(posedge clk) begin
        if (!rst || flush || hazard || !if_valid) begin
            // Reset and bubble share the same all-zero state.
            ex_valid      <= 1'b0;
            ex_pc4        <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_alu_op     <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_pc4        <= if_pc4;
            ex_rs_data    <= rs_data;
            ex_rt_data    <= rt_data;
            ex_imm        <= imm;
            ex_rs         <= rs;
            ex_rt         <= rt;
            ex_dst        <= dec_dst;
            ex_reg_write  <= dec_ctrl.reg_write;
            ex_mem_read   <= dec_ctrl.mem_read;
            ex_mem_write  <= dec_ctrl.mem_write;
            ex_mem_to_reg <= dec_ctrl.mem_to_reg;
            ex_alu_src    <= dec_ctrl.alu_src;
            ex_branch     <= dec_ctrl.branch;
            ex_illegal    <= dec_ctrl.illegal;
            ex_alu_op     <= dec_ctrl.alu_op;
        end
    end

endmodule
